// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the hazard/forwarding controller: forward-select encoding,
// exception FSM states and the destination-shadow entries kept per stage.
package hazard_control_unit_pkg;

  localparam int unsigned HCU_REG_W = 3;
  localparam int unsigned HCU_CNT_W = 3;

  typedef enum logic [1:0] {
    FWD_REG    = 2'd0,
    FWD_P3_ALU = 2'd1,
    FWD_P4_ALU = 2'd2,
    FWD_P4_MEM = 2'd3
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2
  } hcu_state_t;

  typedef struct packed {
    logic                 valid;
    logic [HCU_REG_W-1:0] alu_rd;
    logic                 alu_we;
    logic [HCU_REG_W-1:0] mem_rd;
    logic                 mem_we;
    logic                 mem_read;
  } shadow_t;

  typedef struct packed {
    shadow_t              dst;
    logic [HCU_REG_W-1:0] alu_rm;
    logic [HCU_REG_W-1:0] alu_rn;
    logic [HCU_REG_W-1:0] mem_rn;
    logic [HCU_REG_W-1:0] mem_rd;
  } s2_shadow_t;

endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// Forward-select comparator for one EX operand: youngest valid producer wins,
// and in MEM/WB the load slot beats the ALU slot on the same destination.
module hazard_control_unit_fwd_select
  import hazard_control_unit_pkg::*;
(
  input  logic [HCU_REG_W-1:0] src,
  input  shadow_t              s3,
  input  shadow_t              s4,
  output fwd_sel_t             sel_c
);

  // The EX/MEM load slot cannot forward (load-use stall covers it); fields kept for symmetry.
  logic unused_fields;
  assign unused_fields = ^{s3.mem_rd, s3.mem_we, s3.mem_read, s4.mem_read};

  always_comb begin
    sel_c = FWD_REG;
    if (s3.valid && s3.alu_we && (s3.alu_rd == src)) begin
      sel_c = FWD_P3_ALU;
    end else if (s4.valid && s4.mem_we && (s4.mem_rd == src)) begin
      sel_c = FWD_P4_MEM;
    end else if (s4.valid && s4.alu_we && (s4.alu_rd == src)) begin
      sel_c = FWD_P4_ALU;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard and forwarding controller for the two-slot VLIW pipe: shadows the
// destination info of ID/EX, EX/MEM, MEM/WB and drives stall/flush/forward/exception controls.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned REG_W        = HCU_REG_W,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_alu_rm,
  input  logic [REG_W-1:0] id_alu_rn,
  input  logic [REG_W-1:0] id_alu_rd,
  input  logic [REG_W-1:0] id_mem_rn,
  input  logic [REG_W-1:0] id_mem_rd,
  input  logic             id_alu_regWrite,
  input  logic             id_mem_regWrite,
  input  logic             id_memRead,
  input  logic             id_memWrite,
  input  logic             ex_isBranch,
  input  logic             ex_isJump,
  input  logic             ex_flag_N,
  input  logic             ex_undefinedInstruction,
  output logic             pcWrite,
  output logic             p1_pipeline_regWrite,
  output logic             p2_pipeline_regWrite,
  output logic             p3_pipeline_regWrite,
  output logic             p4_pipeline_regWrite,
  output logic             IF_flush,
  output logic             ID_flush,
  output logic             EX_flush,
  output logic             isException,
  output logic [1:0]       f_alu_reg_rm_sel,
  output logic [1:0]       f_alu_reg_rn_sel,
  output logic [1:0]       f_mem_reg_rn_sel,
  output logic [1:0]       f_mem_reg_rd_sel
);

  hcu_state_t           state_q, state_d;
  logic [HCU_CNT_W-1:0] cnt_q, cnt_d;
  s2_shadow_t           s2_q, s2_d;
  shadow_t              s3_q, s3_d;
  shadow_t              s4_q, s4_d;

  s2_shadow_t id_entry_c;
  logic       load_use_c;
  logic       redirect_c;
  logic       exception_c;
  fwd_sel_t   rm_sel_c, rn_sel_c, mrn_sel_c, mrd_sel_c;

  // Bundle currently in ID, narrowed to shadow layout
  always_comb begin
    id_entry_c              = '0;
    id_entry_c.dst.valid    = id_valid;
    id_entry_c.dst.alu_rd   = HCU_REG_W'(id_alu_rd);
    id_entry_c.dst.alu_we   = id_alu_regWrite;
    id_entry_c.dst.mem_rd   = HCU_REG_W'(id_mem_rd);
    id_entry_c.dst.mem_we   = id_mem_regWrite;
    id_entry_c.dst.mem_read = id_memRead;
    id_entry_c.alu_rm       = HCU_REG_W'(id_alu_rm);
    id_entry_c.alu_rn       = HCU_REG_W'(id_alu_rn);
    id_entry_c.mem_rn       = HCU_REG_W'(id_mem_rn);
    id_entry_c.mem_rd       = HCU_REG_W'(id_mem_rd);
  end

  // Hazard detection against the bundle in EX
  always_comb begin
    load_use_c = s2_q.dst.valid && s2_q.dst.mem_read && s2_q.dst.mem_we &&
                 ((s2_q.dst.mem_rd == id_entry_c.alu_rm) ||
                  (s2_q.dst.mem_rd == id_entry_c.alu_rn) ||
                  (s2_q.dst.mem_rd == id_entry_c.mem_rn) ||
                  (id_memWrite && (s2_q.dst.mem_rd == id_entry_c.mem_rd)));
    redirect_c  = s2_q.dst.valid && (ex_isJump || (ex_isBranch && ex_flag_N));
    exception_c = s2_q.dst.valid && ex_undefinedInstruction;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      s4_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      s4_q    <= s4_d;
    end
  end

  // Exception FSM and pipeline control; exception > redirect > load-use stall
  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    pcWrite              = 1'b1;
    p1_pipeline_regWrite = 1'b1;
    p2_pipeline_regWrite = 1'b1;
    p3_pipeline_regWrite = 1'b1;
    p4_pipeline_regWrite = 1'b1;
    IF_flush             = 1'b0;
    ID_flush             = 1'b0;
    EX_flush             = 1'b0;
    isException          = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (exception_c) begin
          IF_flush = 1'b1;
          ID_flush = 1'b1;
          EX_flush = 1'b1;
          pcWrite  = 1'b0;
          cnt_d    = '0;
          state_d  = ST_DRAIN;
        end else if (redirect_c) begin
          IF_flush = 1'b1;
          ID_flush = 1'b1;
        end else if (load_use_c) begin
          pcWrite              = 1'b0;
          p1_pipeline_regWrite = 1'b0;
          ID_flush             = 1'b1;
        end
      end
      ST_DRAIN: begin
        pcWrite              = 1'b0;
        p1_pipeline_regWrite = 1'b0;
        p2_pipeline_regWrite = 1'b0;
        cnt_d                = cnt_q + HCU_CNT_W'(1);
        if (cnt_q == HCU_CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        isException = 1'b1;
        IF_flush    = 1'b1;
        state_d     = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    // Stale shadows must not leak into the reset cycle
    if (reset) begin
      pcWrite              = 1'b1;
      p1_pipeline_regWrite = 1'b1;
      p2_pipeline_regWrite = 1'b1;
      p3_pipeline_regWrite = 1'b1;
      p4_pipeline_regWrite = 1'b1;
      IF_flush             = 1'b0;
      ID_flush             = 1'b0;
      EX_flush             = 1'b0;
      isException          = 1'b0;
    end
  end

  // Shadows advance with the real pipeline registers; flush or bubble clears valid
  always_comb begin
    s2_d = s2_q;
    s3_d = s3_q;
    s4_d = s4_q;
    if (p2_pipeline_regWrite) begin
      s2_d           = id_entry_c;
      s2_d.dst.valid = id_valid && !ID_flush;
    end
    if (p3_pipeline_regWrite) begin
      s3_d       = s2_q.dst;
      s3_d.valid = s2_q.dst.valid && !EX_flush;
    end
    if (p4_pipeline_regWrite) begin
      s4_d = s3_q;
    end
  end

  hazard_control_unit_fwd_select u_fwd_alu_rm (
    .src(s2_q.alu_rm), .s3(s3_q), .s4(s4_q), .sel_c(rm_sel_c)
  );
  hazard_control_unit_fwd_select u_fwd_alu_rn (
    .src(s2_q.alu_rn), .s3(s3_q), .s4(s4_q), .sel_c(rn_sel_c)
  );
  hazard_control_unit_fwd_select u_fwd_mem_rn (
    .src(s2_q.mem_rn), .s3(s3_q), .s4(s4_q), .sel_c(mrn_sel_c)
  );
  hazard_control_unit_fwd_select u_fwd_mem_rd (
    .src(s2_q.mem_rd), .s3(s3_q), .s4(s4_q), .sel_c(mrd_sel_c)
  );

  assign f_alu_reg_rm_sel = reset ? 2'(FWD_REG) : 2'(rm_sel_c);
  assign f_alu_reg_rn_sel = reset ? 2'(FWD_REG) : 2'(rn_sel_c);
  assign f_mem_reg_rn_sel = reset ? 2'(FWD_REG) : 2'(mrn_sel_c);
  assign f_mem_reg_rd_sel = reset ? 2'(FWD_REG) : 2'(mrd_sel_c);

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit: forwarding distances, load-use
// stall, redirect vs stall priority, exception drain/vector sequence and reset.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_alu_rm, id_alu_rn, id_alu_rd, id_mem_rn, id_mem_rd;
  logic       id_alu_regWrite, id_mem_regWrite, id_memRead, id_memWrite;
  logic       ex_isBranch, ex_isJump, ex_flag_N, ex_undefinedInstruction;
  logic       pcWrite, p1_pipeline_regWrite, p2_pipeline_regWrite;
  logic       p3_pipeline_regWrite, p4_pipeline_regWrite;
  logic       IF_flush, ID_flush, EX_flush, isException;
  logic [1:0] f_alu_reg_rm_sel, f_alu_reg_rn_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel;

  int unsigned vectors;
  int unsigned miscompares;

  // ctrl = {pcWrite, p1, p2, p3, p4, IF_flush, ID_flush, EX_flush, isException}
  localparam logic [15:0] C_IDLE   = 16'b1_1111_000_0;
  localparam logic [15:0] C_STALL  = 16'b0_0111_010_0;
  localparam logic [15:0] C_REDIR  = 16'b1_1111_110_0;
  localparam logic [15:0] C_EXC    = 16'b0_1111_111_0;
  localparam logic [15:0] C_DRAIN  = 16'b0_0011_000_0;
  localparam logic [15:0] C_VECTOR = 16'b1_1111_100_1;

  logic [15:0] ctrl;
  logic [15:0] sels;
  assign ctrl = {7'd0, pcWrite, p1_pipeline_regWrite, p2_pipeline_regWrite,
                 p3_pipeline_regWrite, p4_pipeline_regWrite,
                 IF_flush, ID_flush, EX_flush, isException};
  assign sels = {8'd0, f_alu_reg_rm_sel, f_alu_reg_rn_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel};

  hazard_control_unit #(.REG_W(3), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_alu_rm(id_alu_rm), .id_alu_rn(id_alu_rn), .id_alu_rd(id_alu_rd),
    .id_mem_rn(id_mem_rn), .id_mem_rd(id_mem_rd),
    .id_alu_regWrite(id_alu_regWrite), .id_mem_regWrite(id_mem_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .ex_isBranch(ex_isBranch), .ex_isJump(ex_isJump), .ex_flag_N(ex_flag_N),
    .ex_undefinedInstruction(ex_undefinedInstruction),
    .pcWrite(pcWrite), .p1_pipeline_regWrite(p1_pipeline_regWrite),
    .p2_pipeline_regWrite(p2_pipeline_regWrite), .p3_pipeline_regWrite(p3_pipeline_regWrite),
    .p4_pipeline_regWrite(p4_pipeline_regWrite),
    .IF_flush(IF_flush), .ID_flush(ID_flush), .EX_flush(EX_flush), .isException(isException),
    .f_alu_reg_rm_sel(f_alu_reg_rm_sel), .f_alu_reg_rn_sel(f_alu_reg_rn_sel),
    .f_mem_reg_rn_sel(f_mem_reg_rn_sel), .f_mem_reg_rd_sel(f_mem_reg_rd_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sel4(input int rm, input int rn, input int mrn, input int mrd);
    return {8'd0, 2'(rm), 2'(rn), 2'(mrn), 2'(mrd)};
  endfunction

  task automatic set_id(input int v, input int a_rm, input int a_rn, input int a_rd, input int a_we,
                        input int m_rn, input int m_rd, input int m_we, input int m_ld, input int m_st);
    id_valid        = (v != 0);
    id_alu_rm       = 3'(a_rm);
    id_alu_rn       = 3'(a_rn);
    id_alu_rd       = 3'(a_rd);
    id_alu_regWrite = (a_we != 0);
    id_mem_rn       = 3'(m_rn);
    id_mem_rd       = 3'(m_rd);
    id_mem_regWrite = (m_we != 0);
    id_memRead      = (m_ld != 0);
    id_memWrite     = (m_st != 0);
  endtask

  task automatic idle_id();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_pipe();
    idle_id();
    repeat (3) step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    idle_id();
    ex_isBranch = 1'b0; ex_isJump = 1'b0; ex_flag_N = 1'b0; ex_undefinedInstruction = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", ctrl, C_IDLE);
    check("reset_sel", sels, '0);
    reset = 1'b0;

    // ALU -> ALU forwarding at distance 1, 2, 3 and youngest-wins
    set_id(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); #1;
    check("run_idle", ctrl, C_IDLE);
    step(); set_id(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(); idle_id(); #1;
    check("fwd_p3_alu", sels, sel4(1, 0, 0, 0));
    drain_pipe();
    set_id(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); step(); idle_id(); step();
    set_id(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); step(); idle_id(); #1;
    check("fwd_p4_alu", sels, sel4(2, 0, 0, 0));
    drain_pipe();
    set_id(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); step(); idle_id(); step(); step();
    set_id(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); step(); idle_id(); #1;
    check("fwd_none", sels, '0);
    drain_pipe();
    set_id(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); step();
    set_id(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); step();
    set_id(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); step(); idle_id(); #1;
    check("fwd_young", sels, sel4(1, 0, 0, 0));
    drain_pipe();

    // Load r5 then consumer via mem_rn: one stall cycle, then forward from p4 load data
    set_id(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); step();
    set_id(1, 1, 2, 0, 0, 5, 0, 0, 0, 0); #1;
    check("lu_stall", ctrl, C_STALL);
    step();
    check("lu_release", ctrl, C_IDLE);
    step(); idle_id(); #1;
    check("lu_fwd_mem", sels, sel4(0, 0, 3, 0));
    drain_pipe();
    // mem_rd only counts as a source for stores
    set_id(1, 0, 0, 0, 0, 0, 6, 1, 1, 0); step();
    set_id(1, 1, 2, 0, 0, 4, 6, 0, 0, 0); #1;
    check("lu_rd_unused", ctrl, C_IDLE);
    drain_pipe();
    set_id(1, 0, 0, 0, 0, 0, 6, 1, 1, 0); step();
    set_id(1, 1, 2, 0, 0, 4, 6, 0, 0, 1); #1;
    check("lu_store_rd", ctrl, C_STALL);
    step();
    drain_pipe();

    // Same-bundle ALU and MEM both write r2
    set_id(1, 0, 0, 2, 1, 0, 2, 1, 1, 0); step(); idle_id(); step();
    set_id(1, 0, 2, 0, 0, 0, 0, 0, 0, 0); step(); idle_id(); #1;
    check("fwd_p4_mem_wins", sels, sel4(0, 3, 0, 0));
    drain_pipe();
    set_id(1, 0, 0, 2, 1, 0, 2, 0, 0, 0); step(); idle_id(); step();
    set_id(1, 0, 2, 0, 0, 0, 0, 0, 0, 0); step(); idle_id(); #1;
    check("fwd_p4_alu_only", sels, sel4(0, 2, 0, 0));
    drain_pipe();

    // Taken branch cancels a coincident load-use stall; not-taken lets it stall
    set_id(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); step();
    set_id(1, 1, 2, 0, 0, 5, 0, 0, 0, 0);
    ex_isBranch = 1'b1; ex_flag_N = 1'b1; #1;
    check("br_over_stall", ctrl, C_REDIR);
    step(); ex_isBranch = 1'b0; ex_flag_N = 1'b0;
    drain_pipe();
    set_id(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); step();
    set_id(1, 1, 2, 0, 0, 5, 0, 0, 0, 0);
    ex_isBranch = 1'b1; ex_flag_N = 1'b0; #1;
    check("br_nt_stall", ctrl, C_STALL);
    step(); ex_isBranch = 1'b0;
    drain_pipe();
    ex_isJump = 1'b1; #1;
    check("jump_bubble", ctrl, C_IDLE);
    set_id(1, 0, 0, 1, 1, 0, 0, 0, 0, 0); step(); idle_id(); #1;
    check("jump_taken", ctrl, C_REDIR);
    ex_isJump = 1'b0;
    drain_pipe();

    // Exception beats redirect and stall, then drains 2 cycles and vectors
    set_id(1, 0, 0, 4, 1, 0, 5, 1, 1, 0); step();
    set_id(1, 1, 2, 0, 0, 5, 0, 0, 0, 0);
    ex_undefinedInstruction = 1'b1; ex_isBranch = 1'b1; ex_flag_N = 1'b1; #1;
    check("exc_entry", ctrl, C_EXC);
    step(); idle_id(); ex_isBranch = 1'b0; ex_flag_N = 1'b0; #1;
    check("drain1", ctrl, C_DRAIN);
    step();
    check("drain2", ctrl, C_DRAIN);
    step();
    check("vector", ctrl, C_VECTOR);
    step();
    check("exc_done", ctrl, C_IDLE);
    ex_undefinedInstruction = 1'b0;
    drain_pipe();

    // Reset asserted during DRAIN
    set_id(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); step();
    set_id(1, 0, 0, 7, 1, 0, 0, 0, 0, 0); step(); idle_id();
    ex_undefinedInstruction = 1'b1; #1;
    check("exc_entry2", ctrl, C_EXC);
    step(); ex_undefinedInstruction = 1'b0; #1;
    check("drain_a", ctrl, C_DRAIN);
    reset = 1'b1; #1;
    check("reset_in_drain", ctrl, C_IDLE);
    step(); reset = 1'b0;
    set_id(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("post_reset_run", ctrl, C_IDLE);
    check("post_reset_sel", sels, '0);
    step(); idle_id(); #1;
    check("no_vector", ctrl, C_IDLE);
    check("post_reset_fwd", sels, '0);
    drain_pipe();

    // Reset with a live load in EX: no stall in or after the reset cycle
    set_id(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); step();
    set_id(1, 1, 2, 0, 0, 5, 0, 0, 0, 0);
    reset = 1'b1; #1;
    check("reset_stale_ctrl", ctrl, C_IDLE);
    step(); reset = 1'b0; #1;
    check("stale_no_stall", ctrl, C_IDLE);
    drain_pipe();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central hazard and forwarding controller for the two-slot (ALU + MEM) VLIW pipeline.
- Keeps its own shadow copy of destination-register info through ID/EX, EX/MEM and MEM/WB.
- Drives the forwarding-mux selects read by the EX stage, and the stall/flush/write-enable controls read by the IF, ID and EX stages.
- Runs a small exception state machine that drains the pipe and redirects fetch.

Parameters:
- REG_W, 3, register-address width.
- DRAIN_CYCLES, 2, cycles spent in DRAIN before the vector redirect (1..7).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  bundle in ID is real, not a bubble.
- id_alu_rm, id_alu_rn, id_alu_rd, id_mem_rn, id_mem_rd  in  REG_W each  decoded register fields of the bundle in ID.
- id_alu_regWrite, id_mem_regWrite, id_memRead, id_memWrite  in  1 each  decoded controls of the bundle in ID.
- ex_isBranch, ex_isJump, ex_flag_N, ex_undefinedInstruction  in  1 each  from the bundle in EX.
- pcWrite  out  1  PC enable.
- p1_pipeline_regWrite, p2_pipeline_regWrite, p3_pipeline_regWrite, p4_pipeline_regWrite  out  1 each  pipeline register enables: IF/ID, ID/EX, EX/MEM, MEM/WB.
- IF_flush, ID_flush, EX_flush  out  1 each  clear p1, p2, p3 to a bubble.
- isException  out  1  one-cycle redirect of fetch to the exception vector.
- f_alu_reg_rm_sel, f_alu_reg_rn_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel  out  2 each  EX operand selects.

Behaviour:
- Forward-select encoding: 0 = register file, 1 = p3 ALU result, 2 = p4 ALU write data, 3 = p4 load data.
- Shadow stages S2 (ID/EX), S3 (EX/MEM), S4 (MEM/WB). Each holds valid, alu_rd, alu_we, mem_rd, mem_we, memRead.
  - S2 also holds the four source fields.
  - Shadows advance exactly as the real registers do.
  - A flush or bubble loads valid=0 into the shadow.
- Forwarding: combinational from S2 sources against S3/S4.
  - Youngest producer wins: a match in S3 has priority over a match in S4.
  - S3 ALU write match -> 1.
  - S4 matches: MEM-slot load wins over the ALU slot on the same rd -> 3; otherwise ALU -> 2.
  - No match, or the producer is invalid -> 0.
  - r0 forwards like any other register.
- Load-use stall: condition is S2.valid && S2.memRead && S2.mem_we, and S2.mem_rd equals any ID source in use. Sources in use: alu_rm, alu_rn, mem_rn, and mem_rd when id_memWrite.
  - Stall response: pcWrite=0, p1_pipeline_regWrite=0, ID_flush=1 (bubble into p2).
  - Stall lasts exactly 1 cycle; the load then sits in S3, and the consumer forwards from p4 one cycle later.
- Taken redirect: condition is S2.valid && (ex_isJump || (ex_isBranch && ex_flag_N)).
  - Response: IF_flush=1, ID_flush=1, pcWrite=1.
  - If a stall is also requested, the redirect cancels the stall.
- FSM states are RUN, DRAIN, VECTOR.
  - RUN -> DRAIN on S2.valid && ex_undefinedInstruction; this takes priority over redirect and stall.
  - Entry cycle: IF_flush=ID_flush=EX_flush=1, pcWrite=0.
  - DRAIN: pcWrite=0, p1=p2=0, p3=p4=1. An internal 3-bit counter counts DRAIN_CYCLES cycles, then the FSM goes to VECTOR.
  - VECTOR: isException=1, pcWrite=1, IF_flush=1; next state is RUN.
  - A new exception arriving in DRAIN or VECTOR is ignored, because EX holds a bubble.
- Outputs in RUN with no hazard: all enables 1, all flushes 0, selects 0.
- Reset (any state, any cycle):
  - FSM = RUN, counter = 0, all shadow valid = 0.
  - Outputs that cycle: pcWrite=1, all p*_regWrite=1, flushes=0, isException=0, selects=0.

Decomposition:
- Shared package holds:
  - fwd_sel_t encoding (FWD_REG=0, FWD_P3_ALU=1, FWD_P4_ALU=2, FWD_P4_MEM=3);
  - FSM state enum;
  - the shadow-entry struct.
- One sub-module, fwd_select: a pure combinational comparator instanced four times, one per operand. It takes a source reg plus the S3/S4 entries and returns the select.

Test Plan:
- Back-to-back ALU bundles, ID writes r3, next bundle reads r3 via alu_rm -> f_alu_reg_rm_sel=1 that cycle, =2 if a 1-bundle gap, =0 if a 2-bundle gap.
- Load r5 in EX, ID reads r5 via mem_rn -> 1 cycle: pcWrite=0, p1_pipeline_regWrite=0, ID_flush=1. The following cycle has no stall; one cycle later f_mem_reg_rn_sel=3.
- Same-bundle ALU and MEM both write r2, consumer two cycles later -> select=3; with mem_we=0 -> select=2.
- ex_isBranch=1, ex_flag_N=1 coinciding with a load-use hazard -> IF_flush=ID_flush=1, pcWrite=1, no stall. With ex_flag_N=0 -> the stall occurs instead.
- ex_undefinedInstruction=1 with DRAIN_CYCLES=2 -> cycle0 all flushes=1; cycles 1-2 DRAIN (pcWrite=0, p3/p4=1); cycle3 isException=1; cycle4 back in RUN.
- Reset asserted during DRAIN -> next cycle RUN, isException=0, all selects 0, no spurious stall from stale shadow entries.
